text_cell_arbiter: RTL and testbench

//  Shares the single-port text cell RAM (84x64 cells, {fg[3:0],bg[3:0],char[7:0]}) among three users: video fetch for the 8x8 text area renderer, a host read/write port, and a fill engine.

---
 rtl/text_cell_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_text_cell_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cell_arbiter.sv
// rtl/text_cell_arbiter.sv - single-port text cell RAM arbiter for video, host FIFO and fill engine
//
// Purpose: shares one single-port cell RAM among video fetch (always wins),
// a FIFO-buffered host read/write port, and a whole-array fill engine.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_vid_req/addr               video read request; o_vid_valid/data one cycle later
//   i_host_valid/o_host_ready    host request handshake (we/addr/wdata)
//   o_host_rvalid/rdata          host read return, one cycle after issue
//   i_fill_start/value           fill request; o_fill_busy, o_fill_done status
//   o_ram_en/we/addr/wdata       RAM port, combinational from the grant
//   i_ram_rdata                  RAM read data, one cycle after issue
module text_cell_arbiter #(
  parameter int CELL_COUNT = 5376,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_valid,
  output logic [DATA_W-1:0] o_vid_data,
  input  logic              i_host_valid,
  output logic              o_host_ready,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  input  logic              i_fill_start,
  input  logic [DATA_W-1:0] i_fill_value,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELL_COUNT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_COUNT - 1);
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL, S_DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST} tag_t;

  state_t            state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_val;

  logic              fifo_we    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  // Tag of the read issued last cycle; rd_oob marks a dropped out-of-range
  // read whose consumer must see 0 instead of the stale RAM output.
  tag_t              rd_tag;
  logic              rd_oob;

  logic fifo_empty, fifo_full, push, pop, vid_go, fill_go;
  logic vid_in_range, head_in_range;

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == DEPTH_C);
  assign vid_in_range  = (i_vid_addr < CELLS_A);
  assign head_in_range = (fifo_addr[rd_ptr] < CELLS_A);

  // Grants are suppressed during reset so every output reads 0 then.
  assign o_host_ready = !i_rst && !fifo_full && (state == S_IDLE);
  assign push         = i_host_valid && o_host_ready;
  assign vid_go       = !i_rst && i_vid_req;
  assign fill_go      = !i_rst && !i_vid_req && (state == S_FILL);
  assign pop          = !i_rst && !i_vid_req && (state != S_FILL) && !fifo_empty;

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (vid_go) begin
      if (vid_in_range) begin
        o_ram_en   = 1'b1;
        o_ram_addr = i_vid_addr;
      end
    end else if (fill_go) begin
      o_ram_en    = 1'b1;
      o_ram_we    = 1'b1;
      o_ram_addr  = fill_cnt;
      o_ram_wdata = fill_val;
    end else if (pop && head_in_range) begin
      o_ram_en    = 1'b1;
      o_ram_we    = fifo_we[rd_ptr];
      o_ram_addr  = fifo_addr[rd_ptr];
      o_ram_wdata = fifo_we[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= i_host_we;
      fifo_addr[wr_ptr]  <= i_host_addr;
      fifo_wdata[wr_ptr] <= i_host_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_tag <= TAG_NONE;
      rd_oob <= 1'b0;
    end else if (vid_go) begin
      rd_tag <= TAG_VID;
      rd_oob <= !vid_in_range;
    end else if (pop && !fifo_we[rd_ptr]) begin
      rd_tag <= TAG_HOST;
      rd_oob <= !head_in_range;
    end else begin
      rd_tag <= TAG_NONE;
      rd_oob <= 1'b0;
    end
  end

  assign o_vid_valid   = (rd_tag == TAG_VID);
  assign o_vid_data    = (o_vid_valid && !rd_oob) ? i_ram_rdata : '0;
  assign o_host_rvalid = (rd_tag == TAG_HOST);
  assign o_host_rdata  = (o_host_rvalid && !rd_oob) ? i_ram_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      fill_cnt    <= '0;
      fill_val    <= '0;
      o_fill_busy <= 1'b0;
      o_fill_done <= 1'b0;
    end else begin
      o_fill_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_fill_start) begin
            fill_val    <= i_fill_value;
            o_fill_busy <= 1'b1;
            // A same-cycle push still has to drain ahead of the fill.
            state       <= (fifo_empty && !push) ? S_FILL : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_FILL;
        end
        S_FILL: begin
          if (fill_go) begin
            if (fill_cnt == LAST_ADDR) begin
              fill_cnt    <= '0;
              state       <= S_DONE;
              o_fill_busy <= 1'b0;
              o_fill_done <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_cell_arbiter.sv
// tb/tb_text_cell_arbiter.sv - self-checking bench for text_cell_arbiter
module tb_text_cell_arbiter;
  localparam int CELLS = 5376;
  localparam logic [12:0] CELLS_A = 13'd5376;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vid_req, host_valid, host_we, fill_start;
  logic [12:0] vid_addr, host_addr;
  logic [15:0] host_wdata, fill_value;
  logic        o_vid_valid, o_host_ready, o_host_rvalid, o_fill_busy, o_fill_done;
  logic        o_ram_en, o_ram_we;
  logic [15:0] o_vid_data, o_host_rdata, o_ram_wdata;
  logic [12:0] o_ram_addr;
  logic [15:0] ram_rdata;

  text_cell_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr),
    .o_vid_valid(o_vid_valid), .o_vid_data(o_vid_data),
    .i_host_valid(host_valid), .o_host_ready(o_host_ready),
    .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_rvalid(o_host_rvalid), .o_host_rdata(o_host_rdata),
    .i_fill_start(fill_start), .i_fill_value(fill_value),
    .o_fill_busy(o_fill_busy), .o_fill_done(o_fill_done),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
  );

  // Single-port RAM driven by the DUT's RAM port.
  logic [15:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] <= 16'h0;
    ram_rdata <= 16'h0;
  end
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      else          ram_rdata <= mem[o_ram_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: architectural memory contents in acceptance order,
  // expected host write stream, expected read returns, fill progress.
  logic [15:0] gold [0:CELLS-1];
  logic [28:0] wrq [$];
  logic [15:0] rdq [$];
  bit          vid_pend;
  logic [15:0] vid_exp;
  logic [12:0] fill_next;
  logic [15:0] fill_val_m;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      wrq.delete();
      rdq.delete();
      vid_pend  = 1'b0;
      fill_next = 13'd0;
    end else begin
      chk("vid_valid", 32'(o_vid_valid), 32'(vid_pend));
      if (vid_pend) chk("vid_data", 32'(o_vid_data), 32'(vid_exp));
      if (rdq.size() == 0) chk("host_rvalid_idle", 32'(o_host_rvalid), 32'd0);
      else if (o_host_rvalid) chk("host_rdata", 32'(o_host_rdata), 32'(rdq.pop_front()));
      if (vid_req) begin
        if (vid_addr < CELLS_A) begin
          chk("vid_ram_port", 32'({o_ram_en, o_ram_we, o_ram_addr}), 32'({2'b10, vid_addr}));
          vid_exp = mem[vid_addr];
        end else begin
          chk("vid_oob_no_ram", 32'(o_ram_en), 32'd0);
          vid_exp = 16'h0;
        end
        vid_pend = 1'b1;
      end else begin
        vid_pend = 1'b0;
      end
      if (o_ram_en) chk("ram_addr_legal", 32'(o_ram_addr < CELLS_A), 32'd1);
      if (o_ram_en && o_ram_we) begin
        if (wrq.size() != 0) begin
          chk("host_write_order", 32'({o_ram_addr, o_ram_wdata}), 32'(wrq.pop_front()));
        end else begin
          chk("fill_write", 32'({o_ram_addr, o_ram_wdata}), 32'({fill_next, fill_val_m}));
          fill_next = fill_next + 13'd1;
        end
      end
      if (o_fill_done) begin
        chk("fill_done_count", 32'(fill_next), 32'(CELLS_A));
        chk("fill_done_busy", 32'(o_fill_busy), 32'd0);
        fill_next = 13'd0;
        done_cnt++;
      end
      if (host_valid && o_host_ready) begin
        if (host_we) begin
          if (host_addr < CELLS_A) begin
            gold[host_addr] = host_wdata;
            wrq.push_back({host_addr, host_wdata});
          end
        end else begin
          rdq.push_back((host_addr < CELLS_A) ? gold[host_addr] : 16'h0);
        end
      end
      if (fill_start && !o_fill_busy && !o_fill_done) begin
        fill_val_m = fill_value;
        fill_next  = 13'd0;
        for (int i = 0; i < CELLS; i++) gold[i] = fill_value;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_any();
    return |{o_vid_valid, o_vid_data, o_host_rvalid, o_host_rdata, o_fill_busy,
             o_fill_done, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata};
  endfunction

  int w, nbad, d0;
  bit seen;

  initial begin
    rst = 1'b1; vid_req = 1'b0; vid_addr = 13'h0; host_valid = 1'b0; host_we = 1'b0;
    host_addr = 13'h0; host_wdata = 16'h0; fill_start = 1'b0; fill_value = 16'h0;
    for (int i = 0; i < CELLS; i++) gold[i] = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_zero", 32'(outs_any()), 32'd0);
    chk("reset_ready", 32'(o_host_ready), 32'd1);

    // 1: video stalls a host write; read back after release
    tick(); vid_req = 1'b1; vid_addr = 13'h10;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 13'h10; host_wdata = 16'hC340;
    tick(); host_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("t1_host_stalled", 32'(o_ram_we), 32'd0);
      tick();
    end
    vid_req = 1'b0;
    @(negedge clk);
    chk("t1_write_issue", 32'({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata}), 32'({2'b11, 13'h10, 16'hC340}));
    tick(); host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h10;
    tick(); host_valid = 1'b0;
    @(negedge clk); chk("t1_read_issue", 32'({o_ram_en, o_ram_we, o_ram_addr}), 32'({2'b10, 13'h10}));
    tick();
    @(negedge clk); chk("t1_read_return", 32'({o_host_rvalid, o_host_rdata}), 32'({1'b1, 16'hC340}));

    // 2: five writes under video -> FIFO fills after four, drains in order
    tick(); vid_req = 1'b1; vid_addr = 13'h10; host_valid = 1'b1; host_we = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_addr = 13'h100 + 13'(k); host_wdata = 16'h5000 + 16'(k);
      @(negedge clk); chk("t2_ready", 32'(o_host_ready), 32'(k < 4));
      if (k < 4) tick();
    end
    tick(); vid_req = 1'b0;
    @(negedge clk);
    chk("t2_first_pop", 32'({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata}), 32'({2'b11, 13'h100, 16'h5000}));
    w = 0;
    while (!o_host_ready && w < 10) begin tick(); @(negedge clk); w++; end
    chk("t2_ready_returns", 32'(o_host_ready), 32'd1);
    tick(); host_valid = 1'b0;
    repeat (8) tick();
    chk("t2_last_write_landed", 32'(mem[13'h104]), 32'h5004);
    chk("t2_queue_drained", 32'(wrq.size()), 32'd0);

    // 5: out-of-range video and host reads return 0 without RAM access
    tick(); vid_req = 1'b1; vid_addr = 13'h1FFF;
    @(negedge clk); chk("t5_vid_no_ram", 32'(o_ram_en), 32'd0);
    tick(); vid_req = 1'b0;
    @(negedge clk); chk("t5_vid_return", 32'({o_vid_valid, o_vid_data}), 32'({1'b1, 16'h0}));
    tick(); host_valid = 1'b1; host_we = 1'b0; host_addr = 13'h1500;
    tick(); host_valid = 1'b0;
    @(negedge clk); chk("t5_host_no_ram", 32'(o_ram_en), 32'd0);
    tick();
    @(negedge clk); chk("t5_host_return", 32'({o_host_rvalid, o_host_rdata}), 32'({1'b1, 16'h0}));

    // 4: queued writes drain ahead of the fill
    tick(); vid_req = 1'b1; vid_addr = 13'h10; host_valid = 1'b1; host_we = 1'b1;
    host_addr = 13'h5; host_wdata = 16'h1111;
    tick(); host_addr = 13'h6; host_wdata = 16'h2222;
    tick(); host_valid = 1'b0; fill_start = 1'b1; fill_value = 16'h3C40;
    tick(); fill_start = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("t4_drain_busy_ready", 32'({o_fill_busy, o_host_ready}), 32'd2);
      tick();
    end
    vid_req = 1'b0;
    @(negedge clk);
    chk("t4_first_write", 32'({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata}), 32'({2'b11, 13'h5, 16'h1111}));
    tick();
    @(negedge clk);
    chk("t4_second_write", 32'({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata}), 32'({2'b11, 13'h6, 16'h2222}));
    w = 0;
    while (!o_fill_done && w < 6000) begin tick(); @(negedge clk); w++; end
    chk("t4_done_seen", 32'(o_fill_done), 32'd1);
    tick();
    nbad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== gold[i]) nbad++;
    chk("t4_mem_matches_model", 32'(nbad), 32'd0);
    chk("t4_mem_first", 32'(mem[0]), 32'h3C40);
    chk("t4_mem_cell5", 32'(mem[5]), 32'h3C40);
    chk("t4_mem_last", 32'(mem[CELLS-1]), 32'h3C40);

    // 3: fill 0x0000 with video on alternate cycles
    d0 = done_cnt;
    fill_value = 16'h0000; fill_start = 1'b1;
    tick(); fill_start = 1'b0;
    w = 1; seen = 1'b0;
    while (!seen && w < 12000) begin
      vid_req = w[0];
      vid_addr = 13'($urandom_range(0, CELLS - 1));
      @(negedge clk);
      if (o_fill_done) seen = 1'b1;
      else begin tick(); w++; end
    end
    vid_req = 1'b0;
    chk("t3_done_seen", 32'(seen), 32'd1);
    chk("t3_done_latency", 32'(w >= 10745 && w <= 10760), 32'd1);
    tick();
    chk("t3_single_done", 32'(done_cnt - d0), 32'd1);
    nbad = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== 16'h0) nbad++;
    chk("t3_mem_all_zero", 32'(nbad), 32'd0);

    // 6a: reset with three queued writes while draining
    d0 = done_cnt;
    tick(); vid_req = 1'b1; host_valid = 1'b1; host_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      host_addr = 13'h30 + 13'(k); host_wdata = 16'hAAA0 + 16'(k);
      tick();
    end
    host_valid = 1'b0; fill_start = 1'b1; fill_value = 16'h5A5A;
    tick(); fill_start = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    chk("t6a_outputs_zero", 32'(outs_any()), 32'd0);
    chk("t6a_ready", 32'(o_host_ready), 32'd1);
    repeat (10) tick();
    chk("t6a_queue_discarded", 32'(mem[13'h30]), 32'h0);

    // 6b: reset at fill counter 100
    fill_value = 16'h7E7E; fill_start = 1'b1;
    tick(); fill_start = 1'b0;
    w = 0;
    @(negedge clk); #1;
    while (fill_next != 13'd100 && w < 400) begin tick(); @(negedge clk); #1; w++; end
    chk("t6b_reached_100", 32'(fill_next), 32'd100);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t6b_outputs_zero", 32'(outs_any()), 32'd0);
    chk("t6b_ready", 32'(o_host_ready), 32'd1);
    repeat (5600) tick();
    chk("t6_no_done_pulse", 32'(done_cnt - d0), 32'd0);
    chk("t6b_cell99_written", 32'(mem[99]), 32'h7E7E);
    chk("t6b_cell100_untouched", 32'(mem[100]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
